range_stat_accum: RTL
=====================

RANGE_STAT_ACCUM -- requirements
Module: range_stat_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed sample width per channel.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: log2 of mini-batch size.
REQ-003 SHALL have parameter MINI_BATCH, default 8: samples per batch, SHALL equal 2**ADDR_WIDTH (elaboration error otherwise).
REQ-004 SHALL have parameter NUM_CH, default 4: parallel channels.
REQ-005 SHALL derive ACC_WIDTH = DATA_WIDTH+ADDR_WIDTH.
REQ-006 Ports: clk, input, 1, single clock; all logic rising-edge.
REQ-007 Ports: rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 Ports: clear, input, 1, synchronous batch abort.
REQ-009 Ports: in_valid, input, 1, sample vector valid.
REQ-010 Ports: in_ready, output, 1, block accepts sample vector.
REQ-011 Ports: x_in, input, NUM_CH*DATA_WIDTH, signed samples, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Ports: out_valid, output, 1, batch result valid.
REQ-013 Ports: out_ready, input, 1, consumer accepts result.
REQ-014 Ports: sum_out, output, NUM_CH*ACC_WIDTH, signed batch sums.
REQ-015 Ports: max_out / min_out, output, NUM_CH*DATA_WIDTH each, signed batch extremes.
REQ-016 Ports: range_out, output, NUM_CH*(DATA_WIDTH+1), unsigned max-min.
REQ-017 Ports: mean_out, output, NUM_CH*DATA_WIDTH, signed sum arithmetically shifted right by ADDR_WIDTH (floor).

Function
REQ-018 SHALL accept a sample vector only on cycles where in_valid && in_ready.
REQ-019 SHALL implement states IDLE (count 0), ACCUM (1..MINI_BATCH-1 accepted), DONE (result held).
REQ-020 Transitions: IDLE->ACCUM on accept; ACCUM->DONE on accept of sample MINI_BATCH; DONE->IDLE on out_valid && out_ready; any->IDLE on clear.
REQ-021 in_ready SHALL be 1 in IDLE/ACCUM, 0 in DONE; in_valid in DONE SHALL be ignored.
REQ-022 Per channel, on accept: acc += sign-extended x; max = x if x > max; min = x if x < min.
REQ-023 Accumulator SHALL be ACC_WIDTH wide; overflow is impossible and no saturation is applied.
REQ-024 Latency: out_valid SHALL rise the cycle after sample MINI_BATCH is accepted, results including that sample.
REQ-025 Result outputs SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-026 After the output handshake, out_valid SHALL be 0 and in_ready 1 the next cycle (one-cycle bubble), working registers reinitialised.
REQ-027 Working max/min SHALL reinitialise to -2**(DATA_WIDTH-1) / 2**(DATA_WIDTH-1)-1 at start of each batch.
REQ-028 clear SHALL have priority over accept and output handshake: discard partial batch and held result, out_valid=0 next cycle.
REQ-029 range_out SHALL be computed in DATA_WIDTH+1 bits without wrap (full-scale range 2**DATA_WIDTH-1 representable).
REQ-030 mean_out SHALL be the low DATA_WIDTH bits of sum>>>ADDR_WIDTH (always in range).

Reset
REQ-031 On rst_n=0 state SHALL be IDLE, count 0, out_valid 0, in_ready 1 after release, all result outputs 0, working max/min at REQ-027 values.
REQ-032 Reset mid-batch or during DONE SHALL discard all data; first post-reset batch SHALL be unaffected.

Structure
REQ-033 Package range_stat_pkg SHALL hold the state enum, ACC_WIDTH derivation function and max/min init constants.
REQ-034 Per-channel datapath SHALL be sub-module range_stat_lane (acc/max/min/range/mean), instantiated NUM_CH times; FSM and counter SHALL be single-instance in range_stat_accum.

Verification (DATA_WIDTH=16, MINI_BATCH=8, NUM_CH=2, out_ready=1 unless stated)
REQ-035 ch0 samples 1..8 -> sum 36, max 8, min 1, range 7, mean 4; out_valid exactly one cycle after 8th accept.
REQ-036 ch1 samples -8..-1 -> sum -36, max -1, min -8, range 7, mean -5.
REQ-037 ch0 alternating 32767/-32768 x4 -> sum -4, max 32767, min -32768, range 65535, mean -1.
REQ-038 out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid held, outputs stable, in_ready=0, no samples absorbed; next batch correct.
REQ-039 clear after 5 samples (value 100), then samples 1..8 -> sum 36, max 8, min 1; no residue of 100.
REQ-040 rst_n pulsed low after 3 samples -> all outputs 0, out_valid 0; following 1..8 batch -> sum 36, mean 4.

Source files
------------

// File: rtl/range_stat_pkg.sv
// Shared types and helpers for the mini-batch range/statistics accumulator.
package range_stat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int acc_width(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

  // Working extremes start at the opposite end of the signed range so the first sample always wins.
  function automatic logic [63:0] max_init(input int data_width);
    return ~(64'd0) << (data_width - 1);
  endfunction

  function automatic logic [63:0] min_init(input int data_width);
    return ~max_init(data_width);
  endfunction

endpackage

// File: rtl/range_stat_lane.sv
// One channel of the batch datapath: running sum and extremes, plus the
// registered sum/max/min/range/mean captured when the last sample lands.
module range_stat_lane
  import range_stat_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [DATA_WIDTH-1:0] min_out,
  output logic [DATA_WIDTH:0]   range_out,
  output logic [DATA_WIDTH-1:0] mean_out
);

  localparam logic [63:0] MAX_INIT_W = max_init(DATA_WIDTH);
  localparam logic [63:0] MIN_INIT_W = min_init(DATA_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = MAX_INIT_W[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] MIN_INIT = MIN_INIT_W[DATA_WIDTH-1:0];

  logic signed [DATA_WIDTH-1:0] x_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [DATA_WIDTH-1:0] max_r;
  logic signed [DATA_WIDTH-1:0] min_r;
  logic signed [ACC_WIDTH-1:0]  acc_nxt_s;
  logic signed [DATA_WIDTH-1:0] max_nxt_s;
  logic signed [DATA_WIDTH-1:0] min_nxt_s;
  logic [DATA_WIDTH:0]          range_nxt_s;
  logic [DATA_WIDTH-1:0]        mean_nxt_s;

  assign x_s = x;

  // Candidate values including the current sample.
  always_comb begin
    acc_nxt_s = acc_r + {{ADDR_WIDTH{x_s[DATA_WIDTH-1]}}, x_s};
    if (x_s > max_r) begin
      max_nxt_s = x_s;
    end else begin
      max_nxt_s = max_r;
    end
    if (x_s < min_r) begin
      min_nxt_s = x_s;
    end else begin
      min_nxt_s = min_r;
    end
    // One extra bit keeps full-scale range (max - min) from wrapping.
    range_nxt_s = {max_nxt_s[DATA_WIDTH-1], max_nxt_s} - {min_nxt_s[DATA_WIDTH-1], min_nxt_s};
    // Top DATA_WIDTH bits of the sum are exactly floor(sum / 2**ADDR_WIDTH).
    mean_nxt_s  = acc_nxt_s[ADDR_WIDTH +: DATA_WIDTH];
  end

  // Working registers and result capture; working state restarts as results are latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      max_r     <= MAX_INIT;
      min_r     <= MIN_INIT;
      sum_out   <= {ACC_WIDTH{1'b0}};
      max_out   <= {DATA_WIDTH{1'b0}};
      min_out   <= {DATA_WIDTH{1'b0}};
      range_out <= {(DATA_WIDTH+1){1'b0}};
      mean_out  <= {DATA_WIDTH{1'b0}};
    end else if (clear) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      max_r     <= MAX_INIT;
      min_r     <= MIN_INIT;
      sum_out   <= {ACC_WIDTH{1'b0}};
      max_out   <= {DATA_WIDTH{1'b0}};
      min_out   <= {DATA_WIDTH{1'b0}};
      range_out <= {(DATA_WIDTH+1){1'b0}};
      mean_out  <= {DATA_WIDTH{1'b0}};
    end else if (accept) begin
      if (last) begin
        sum_out   <= acc_nxt_s;
        max_out   <= max_nxt_s;
        min_out   <= min_nxt_s;
        range_out <= range_nxt_s;
        mean_out  <= mean_nxt_s;
        acc_r     <= {ACC_WIDTH{1'b0}};
        max_r     <= MAX_INIT;
        min_r     <= MIN_INIT;
      end else begin
        acc_r <= acc_nxt_s;
        max_r <= max_nxt_s;
        min_r <= min_nxt_s;
      end
    end
  end

endmodule

// File: rtl/range_stat_accum.sv
// Mini-batch statistics accumulator: NUM_CH lanes share one batch FSM and
// sample counter; results are held until the consumer takes them.
module range_stat_accum
  import range_stat_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int MINI_BATCH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]            x_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NUM_CH*(DATA_WIDTH+ADDR_WIDTH)-1:0] sum_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]            max_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]            min_out,
  output logic [NUM_CH*(DATA_WIDTH+1)-1:0]        range_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]            mean_out
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MINI_BATCH - 1);

  if (MINI_BATCH != (1 << ADDR_WIDTH)) begin : g_bad_batch
    $error("range_stat_accum: MINI_BATCH must equal 2**ADDR_WIDTH");
  end

  state_e                state_r;
  state_e                state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_nxt_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  accept_s;
  logic                  last_s;

  assign accept_s  = in_valid && in_ready_r && !clear;
  assign last_s    = accept_s && (cnt_r == LAST_IDX);
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

  // Batch FSM next state and sample count; clear overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (accept_s) begin
            cnt_nxt_s = cnt_r + ADDR_WIDTH'(1);
            if (last_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_ACCUM;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {ADDR_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_DONE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    range_stat_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .accept    (accept_s),
      .last      (last_s),
      .x         (x_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .sum_out   (sum_out[c*ACC_WIDTH +: ACC_WIDTH]),
      .max_out   (max_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .min_out   (min_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .range_out (range_out[c*(DATA_WIDTH+1) +: (DATA_WIDTH+1)]),
      .mean_out  (mean_out[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
